bcd_mmss_timer: RTL and testbench

//   Four-digit BCD MM:SS countdown timer clocked by the 1 Hz divided clock.
//   Its four BCD digits feed the downstream 7-segment decoder and scanner.
//   It adds load, start and pause control, a done flag and status LEDs.

---
 rtl/bcd_mmss_timer_if.sv | 30 +++
 rtl/bcd_mmss_timer.sv | 133 +++++++++++++
 tb/tb_bcd_mmss_timer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bcd_mmss_timer_if.sv
// Control, preset and display bundle of the MM:SS countdown timer.
//   master : drives load/start/pause and the ld_* preset digits, observes the outputs
//   slave  : the timer; observes controls and presets, drives bcd_* digits,
//            running, done and the one-hot status led
interface bcd_mmss_timer_if;
  logic       load;
  logic       start;
  logic       pause;
  logic [3:0] ld_mt;
  logic [3:0] ld_mu;
  logic [3:0] ld_st;
  logic [3:0] ld_su;
  logic [3:0] bcd_mt;
  logic [3:0] bcd_mu;
  logic [3:0] bcd_st;
  logic [3:0] bcd_su;
  logic       running;
  logic       done;
  logic [3:0] led;

  modport master (
    output load, start, pause, ld_mt, ld_mu, ld_st, ld_su,
    input  bcd_mt, bcd_mu, bcd_st, bcd_su, running, done, led
  );

  modport slave (
    input  load, start, pause, ld_mt, ld_mu, ld_st, ld_su,
    output bcd_mt, bcd_mu, bcd_st, bcd_su, running, done, led
  );
endinterface

// File: rtl/bcd_mmss_timer.sv
// Four-digit BCD MM:SS countdown timer clocked by the 1 Hz divided clock.
// Feeds the 7-segment decoder/scanner with registered BCD digits and adds
// load/start/pause control, a done flag and one-hot status LEDs.
//   clk_1hz : 1 Hz clock, all state changes on posedge
//   rst     : asynchronous, active-low reset
//   bus     : slave side of bcd_mmss_timer_if (controls, presets, digits, status)
// Parameters: MT_MAX / ST_MAX are the largest minutes-tens / seconds-tens digits.
// Build option: define DONE_BLINK_EN to make led[3] blink (toggle each edge)
// while in DONE; otherwise led[3] is steady in DONE.
module bcd_mmss_timer #(
  parameter int unsigned MT_MAX = 5,
  parameter int unsigned ST_MAX = 5
) (
  input logic             clk_1hz,
  input logic             rst,
  bcd_mmss_timer_if.slave bus
);

  localparam logic [3:0] MtMax = 4'(MT_MAX);
  localparam logic [3:0] StMax = 4'(ST_MAX);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] mt_q, mu_q, st_q, su_q;
  logic [3:0] mt_d, mu_d, st_d, su_d;
  logic       running_q, done_q;
  logic [3:0] led_q, led_d;

  // One-second decrement with BCD borrow chain.
  logic [3:0] dec_mt, dec_mu, dec_st, dec_su;
  logic       borrow_su, borrow_st, borrow_mu;
  logic       is_zero, dec_zero;

  assign borrow_su = (su_q == 4'd0);
  assign borrow_st = borrow_su && (st_q == 4'd0);
  assign borrow_mu = borrow_st && (mu_q == 4'd0);
  assign dec_su    = borrow_su ? 4'd9 : su_q - 4'd1;
  assign dec_st    = !borrow_su ? st_q : ((st_q == 4'd0) ? StMax : st_q - 4'd1);
  assign dec_mu    = !borrow_st ? mu_q : ((mu_q == 4'd0) ? 4'd9 : mu_q - 4'd1);
  assign dec_mt    = borrow_mu ? mt_q - 4'd1 : mt_q;
  assign is_zero   = ({mt_q, mu_q, st_q, su_q} == 16'h0000);
  assign dec_zero  = ({dec_mt, dec_mu, dec_st, dec_su} == 16'h0000);

  // Next state; priority load > pause > start > count.
  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mu_d    = mu_q;
    st_d    = st_q;
    su_d    = su_q;
    if (bus.load) begin
      mt_d    = (bus.ld_mt > MtMax) ? MtMax : bus.ld_mt;
      mu_d    = (bus.ld_mu > 4'd9)  ? 4'd9  : bus.ld_mu;
      st_d    = (bus.ld_st > StMax) ? StMax : bus.ld_st;
      su_d    = (bus.ld_su > 4'd9)  ? 4'd9  : bus.ld_su;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Start never decrements; a zero preset finishes immediately.
          if (!bus.pause && bus.start) state_d = is_zero ? StDone : StRun;
        end
        StRun: begin
          if (bus.pause) begin
            state_d = StPause;
          end else if (!bus.start) begin
            mt_d = dec_mt;
            mu_d = dec_mu;
            st_d = dec_st;
            su_d = dec_su;
            if (dec_zero) state_d = StDone;
          end
        end
        StPause: begin
          if (!bus.pause && bus.start) state_d = StRun;
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Status follows the next state so the registered LEDs match the state register.
  always_comb begin
    led_d = 4'b0000;
    unique case (state_d)
      StIdle:  led_d[0] = 1'b1;
      StRun:   led_d[1] = 1'b1;
      StPause: led_d[2] = 1'b1;
      StDone: begin
`ifdef DONE_BLINK_EN
        // 1 on entry, then toggles; cleared whenever DONE is left.
        led_d[3] = (state_q == StDone) ? ~led_q[3] : 1'b1;
`else
        led_d[3] = 1'b1;
`endif
      end
      default: led_d = 4'b0001;
    endcase
  end

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      mt_q      <= 4'd0;
      mu_q      <= 4'd0;
      st_q      <= 4'd0;
      su_q      <= 4'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= 4'b0001;
    end else begin
      state_q   <= state_d;
      mt_q      <= mt_d;
      mu_q      <= mu_d;
      st_q      <= st_d;
      su_q      <= su_d;
      running_q <= (state_d == StRun);
      done_q    <= (state_d == StDone);
      led_q     <= led_d;
    end
  end

  assign bus.bcd_mt  = mt_q;
  assign bus.bcd_mu  = mu_q;
  assign bus.bcd_st  = st_q;
  assign bus.bcd_su  = su_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.led     = led_q;

endmodule

// File: tb/tb_bcd_mmss_timer.sv
// Scoreboard bench for bcd_mmss_timer: directed stimulus pushes the expected
// outputs after each clock edge; a separate monitor pops and compares.
// Expected led[3] in DONE follows DONE_BLINK_EN when that macro is defined.
module tb_bcd_mmss_timer;

  localparam int Idle  = 0;
  localparam int Run   = 1;
  localparam int Pause = 2;
  localparam int Done  = 3;

  logic clk_1hz = 1'b0;
  logic rst     = 1'b0;

  always #5 clk_1hz = ~clk_1hz;

  bcd_mmss_timer_if bus ();

  bcd_mmss_timer #(
    .MT_MAX(5),
    .ST_MAX(5)
  ) dut (
    .clk_1hz(clk_1hz),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    string       name;
    logic [15:0] dig;
    logic        running;
    logic        done;
    logic [3:0]  led;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_run = 0;
  event async_chk;

  function automatic exp_t mk(input string name, input logic [15:0] dig, input int st);
    exp_t e;
    e.name    = name;
    e.dig     = dig;
    e.running = (st == Run);
    e.done    = (st == Done);
    case (st)
      Idle:    e.led = 4'b0001;
      Run:     e.led = 4'b0010;
      Pause:   e.led = 4'b0100;
      default: e.led = 4'b1000;
    endcase
    if (st == Done) begin
`ifdef DONE_BLINK_EN
      e.led[3] = ((done_run % 2) == 0);
`endif
      done_run++;
    end else begin
      done_run = 0;
    end
    return e;
  endfunction

  task automatic cyc(input string name, input logic ld, input logic sta, input logic pa,
                     input logic [15:0] pre, input logic [15:0] dig, input int st);
    @(negedge clk_1hz);
    bus.load  = ld;
    bus.start = sta;
    bus.pause = pa;
    {bus.ld_mt, bus.ld_mu, bus.ld_st, bus.ld_su} = pre;
    sb.push_back(mk(name, dig, st));
  endtask

  // Monitor: compares after every active edge, or on demand for async events.
  initial begin
    forever begin
      @(posedge clk_1hz or async_chk);
      #1;
      if (sb.size() > 0) begin
        exp_t        e;
        logic [15:0] act;
        e   = sb.pop_front();
        act = {bus.bcd_mt, bus.bcd_mu, bus.bcd_st, bus.bcd_su};
        checks++;
        if ({act, bus.running, bus.done, bus.led} !== {e.dig, e.running, e.done, e.led}) begin
          errors++;
          $display("FAIL %s: got dig=%h run=%b done=%b led=%b, expected dig=%h run=%b done=%b led=%b",
                   e.name, act, bus.running, bus.done, bus.led,
                   e.dig, e.running, e.done, e.led);
        end
      end
    end
  end

  initial begin
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.ld_mt = 4'd0;
    bus.ld_mu = 4'd0;
    bus.ld_st = 4'd0;
    bus.ld_su = 4'd0;

    // Reset state.
    cyc("reset_state", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, Idle);
    @(negedge clk_1hz);
    rst = 1'b1;

    // 01:00 countdown: mu borrow, st reload to 5.
    cyc("load_0100",   1'b1, 1'b0, 1'b0, 16'h0100, 16'h0100, Idle);
    cyc("start_0100",  1'b0, 1'b1, 1'b0, 16'h0000, 16'h0100, Run);
    cyc("dec_0059",    1'b0, 1'b0, 1'b0, 16'h0000, 16'h0059, Run);
    cyc("dec_0058",    1'b0, 1'b0, 1'b0, 16'h0000, 16'h0058, Run);
    cyc("dec_0057",    1'b0, 1'b0, 1'b0, 16'h0000, 16'h0057, Run);

    // Asynchronous reset mid-count.
    @(negedge clk_1hz);
    #1 rst = 1'b0;
    #1 sb.push_back(mk("async_reset", 16'h0000, Idle));
    -> async_chk;
    cyc("reset_hold",  1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, Idle);
    @(negedge clk_1hz);
    rst = 1'b1;

    // 10:00 -> 09:59: full borrow chain into minutes tens.
    cyc("load_1000",   1'b1, 1'b0, 1'b0, 16'h1000, 16'h1000, Idle);
    cyc("start_1000",  1'b0, 1'b1, 1'b0, 16'h0000, 16'h1000, Run);
    cyc("dec_0959",    1'b0, 1'b0, 1'b0, 16'h0000, 16'h0959, Run);

    // 00:02 -> DONE; start/pause ignored in DONE, led[3] blink pattern.
    cyc("load_0002",   1'b1, 1'b0, 1'b0, 16'h0002, 16'h0002, Idle);
    cyc("start_0002",  1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002, Run);
    cyc("dec_0001",    1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, Run);
    cyc("done_0000",   1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, Done);
    cyc("done_start",  1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, Done);
    cyc("done_pause",  1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, Done);
    cyc("done_both",   1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, Done);

    // Start from 00:00 goes straight to DONE.
    cyc("load_zero",   1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, Idle);
    cyc("start_zero",  1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, Done);

    // Pause / resume at 12:34.
    cyc("load_1234",   1'b1, 1'b0, 1'b0, 16'h1234, 16'h1234, Idle);
    cyc("start_1234",  1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, Run);
    cyc("pause_1",     1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234, Pause);
    cyc("pause_2",     1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234, Pause);
    cyc("pause_start", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1234, Pause);
    cyc("resume",      1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, Run);
    cyc("dec_1233",    1'b0, 1'b0, 1'b0, 16'h0000, 16'h1233, Run);

    // Preset clamping and load priority over start/pause.
    cyc("clamp",       1'b1, 1'b0, 1'b0, 16'h9F7C, 16'h5959, Idle);
    cyc("load_all",    1'b1, 1'b1, 1'b1, 16'h0305, 16'h0305, Idle);
    cyc("start_0305",  1'b0, 1'b1, 1'b0, 16'h0000, 16'h0305, Run);
    cyc("dec_0304",    1'b0, 1'b0, 1'b0, 16'h0000, 16'h0304, Run);

    @(negedge clk_1hz);
    @(negedge clk_1hz);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
